// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
//   ADDR_W / DATA_W : word address and data widths
//   MEM_WORDS       : default count of implemented data-memory words
//   state_t         : sequencer states
//   req_t           : one queued processor request
package mem_access_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int words);
    return int'(addr) < words;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Processor-side request/response bus of the memory access unit.
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err            : response channel
//   master : processor side, slave : the unit
interface mem_access_unit_if;
  import mem_access_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_access_unit_req_fifo.sv
// req_fifo: small synchronous request queue.
//   clk, reset    : clock, synchronous active-high reset (empties queue)
//   push, wdata   : enqueue (ignored when full)
//   pop, rdata    : dequeue (ignored when empty); rdata shows the head
//   full, empty   : occupancy flags
// A push and a pop in the same cycle both take effect.
module req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: queues processor load/store requests and runs them one
// at a time against a word-addressed data memory with combinational read.
//   clk, reset               : clock, synchronous active-high reset
//   bus (slave)              : request/response handshake bus
//   mem_write/addr/datain    : data-memory write strobe, address, write data
//   mem_dataout              : data-memory read data
//   rd_count / wr_count      : completed in-range loads / stores (saturating)
//
// state  | meaning
// IDLE   | no operation in flight, waiting for a queued request
// ACCESS | single cycle driving the memory for the operation register
// RESP   | response presented, held until rsp_ready
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS  = mem_access_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  state_t            state, state_nxt;
  req_t              push_req, head_req, op_q;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              op_in_range, access_en;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [15:0]       rd_cnt_q, wr_cnt_q;

  // Ready is masked during reset so nothing is accepted while flushing.
  assign bus.req_ready = !fifo_full && !reset;
  assign fifo_push     = bus.req_valid && bus.req_ready;

  always_comb begin
    push_req       = '0;
    push_req.write = bus.req_write;
    push_req.addr  = bus.req_addr;
    push_req.wdata = bus.req_wdata;
  end

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (push_req),
    .pop   (fifo_pop),
    .rdata (head_req),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ACCESS;
          fifo_pop  = 1'b1;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            state_nxt = ACCESS;
            fifo_pop  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         op_q <= '0;
    else if (fifo_pop) op_q <= head_req;
  end

  assign op_in_range = addr_in_range(op_q.addr, MEM_WORDS);

  // Response and counters are captured on the ACCESS->RESP edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state == ACCESS) begin
      rdata_q <= (op_in_range && !op_q.write) ? mem_dataout : '0;
      err_q   <= !op_in_range;
      if (op_in_range) begin
        if (op_q.write) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end else begin
          if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

  // Outputs are masked by reset so an in-flight store is dropped the moment
  // reset rises, not one edge later.
  assign access_en     = (state == ACCESS) && !reset;
  assign mem_write     = access_en && op_q.write && op_in_range;
  assign mem_addr      = access_en ? op_q.addr  : '0;
  assign mem_datain    = access_en ? op_q.wdata : '0;

  assign bus.rsp_valid = (state == RESP) && !reset;
  assign bus.rsp_rdata = reset ? '0 : rdata_q;
  assign bus.rsp_err   = !reset && err_q;
  assign rd_count      = reset ? '0 : rd_cnt_q;
  assign wr_count      = reset ? '0 : wr_cnt_q;

endmodule
